// File: rtl/dot_product_reader.sv
// dot_product_reader
//   Read-side sequencer for the dot-product datapath. On start it streams addresses
//   0..length-1 to the A and B operand memories, multiplies the returned operand pairs,
//   accumulates them and presents the sum through a valid/ready handshake.
//
//   Configuration macro: DOT_SIGNED_EN
//     defined   - operands are two's complement, sign-extended; result is two's complement
//     undefined - operands are unsigned, zero-extended (default)
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         request a dot product (sampled only in idle)
//   length        element count 0..2**ADDR_WIDTH (sampled with start)
//   read_en       registered read strobe to both memories
//   read_address  registered shared read address
//   data_a        memory A read data, valid one cycle after a read_en edge
//   data_b        memory B read data, same timing as data_a
//   busy          high whenever not idle
//   result        accumulated sum, stable while result_valid
//   result_valid  result available
//   result_ready  consumer accepts result when high together with result_valid

module dot_product_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic                  read_en_q, read_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  result_q, result_d;
  logic                  valid_q, valid_d;

  logic [ACC_WIDTH-1:0]  ext_a, ext_b, product;
  logic                  last_addr;

`ifdef DOT_SIGNED_EN
  assign ext_a = {{(ACC_WIDTH - DATA_WIDTH){data_a[DATA_WIDTH-1]}}, data_a};
  assign ext_b = {{(ACC_WIDTH - DATA_WIDTH){data_b[DATA_WIDTH-1]}}, data_b};
`else
  assign ext_a = {{(ACC_WIDTH - DATA_WIDTH){1'b0}}, data_a};
  assign ext_b = {{(ACC_WIDTH - DATA_WIDTH){1'b0}}, data_b};
`endif

  // Truncated product is exact modulo 2**ACC_WIDTH for both signednesses.
  assign product = ext_a * ext_b;

  // Compare at ADDR_WIDTH+1 bits so a full-length run (2**ADDR_WIDTH) ends on the top address.
  assign last_addr = ({1'b0, addr_q} == (len_q - {{ADDR_WIDTH{1'b0}}, 1'b1}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      read_en_q  <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      rd_valid_q <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_en_q  <= read_en_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rd_valid_q <= rd_valid_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    read_en_d  = 1'b0;
    addr_d     = addr_q;
    len_d      = len_q;
    rd_valid_d = read_en_q;  // memory data returns one cycle after the strobe
    acc_d      = acc_q;
    result_d   = result_q;
    valid_d    = valid_q;

    if (rd_valid_q) begin
      acc_d = acc_q + product;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length != '0) begin
            acc_d     = '0;
            len_d     = length;
            read_en_d = 1'b1;
            addr_d    = '0;
            state_d   = StRead;
          end else begin
            result_d = '0;
            valid_d  = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StRead: begin
        if (last_addr) begin
          state_d = StDrain;
        end else begin
          read_en_d = 1'b1;
          addr_d    = addr_q + 1'b1;
        end
      end
      StDrain: begin
        // Once the delayed strobe drops the final product has been accumulated.
        if (!rd_valid_q) begin
          result_d = acc_q;
          valid_d  = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign read_en      = read_en_q;
  assign read_address = addr_q;
  assign busy         = (state_q != StIdle);
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_dot_product_reader.sv
// Self-checking bench for dot_product_reader with directed vectors and a behavioural
// synchronous-read memory pair driven from local arrays.

module tb_dot_product_reader;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 2 * DW + AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   length = '0;
  logic          read_en;
  logic [AW-1:0] read_address;
  logic [DW-1:0] data_a = '0;
  logic [DW-1:0] data_b = '0;
  logic          busy;
  logic [CW-1:0] result;
  logic          result_valid;
  logic          result_ready = 1'b0;

  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];

  int tests = 0;
  int fails = 0;

  dot_product_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ACC_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .length      (length),
    .read_en     (read_en),
    .read_address(read_address),
    .data_a      (data_a),
    .data_b      (data_b),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_en) begin
      data_a <= mem_a[read_address];
      data_b <= mem_b[read_address];
    end
  end

  // Pulse start with length n, then watch until result_valid (bounded).
  // cyc: edges after the start-sampling edge until result_valid is seen.
  task automatic run_op(input int n, output int cyc, output int nre, output int addr_err);
    @(posedge clk); #1;
    start  = 1'b1;
    length = n[AW:0];
    @(posedge clk); #1;
    start  = 1'b0;
    length = '0;
    cyc = 0; nre = 0; addr_err = 0;
    while (!result_valid && cyc < 100) begin
      if (read_en) begin
        if (read_address != nre[AW-1:0]) addr_err++;
        nre++;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({read_en, read_address, busy, result, result_valid} !== '0) begin
      $display("FAIL reset_outputs: got en=%b addr=%0d busy=%b res=%0d v=%b, want all 0",
               read_en, read_address, busy, result, result_valid);
      fails++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc, nre, aerr;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(i + 5);
    end
    run_op(4, cyc, nre, aerr);
    tests++;
    if (result !== CW'(70)) begin
      $display("FAIL basic_result: got %0d want 70", result); fails++;
    end
    tests++;
    if (cyc != 6) begin
      $display("FAIL basic_latency: got %0d want 6", cyc); fails++;
    end
    tests++;
    if (nre != 4 || aerr != 0) begin
      $display("FAIL basic_reads: got %0d reads %0d bad addrs, want 4 reads 0 bad", nre, aerr);
      fails++;
    end
    handshake();
    tests++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== CW'(70)) begin
      $display("FAIL basic_ack: got v=%b busy=%b res=%0d want v=0 busy=0 res=70",
               result_valid, busy, result);
      fails++;
    end
  endtask

  task automatic test_full_length();
    int cyc, nre, aerr;
    logic [CW-1:0] exp;
`ifdef DOT_SIGNED_EN
    exp = CW'(16);
`else
    exp = CW'(20'hFE010);
`endif
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'hFF;
      mem_b[i] = 8'hFF;
    end
    run_op(16, cyc, nre, aerr);
    tests++;
    if (result !== exp) begin
      $display("FAIL full_result: got %0h want %0h", result, exp); fails++;
    end
    tests++;
    if (nre != 16 || aerr != 0 || cyc != 18) begin
      $display("FAIL full_reads: got %0d reads %0d bad latency %0d, want 16 0 18",
               nre, aerr, cyc);
      fails++;
    end
    handshake();
  endtask

  task automatic test_zero_length();
    int cyc, nre, aerr;
    run_op(0, cyc, nre, aerr);
    tests++;
    if (result !== '0 || cyc != 0 || nre != 0) begin
      $display("FAIL zero_len: got res=%0d cyc=%0d reads=%0d want 0 0 0", result, cyc, nre);
      fails++;
    end
    handshake();
    tests++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL zero_ack: got v=%b busy=%b want 0 0", result_valid, busy); fails++;
    end
  endtask

  task automatic test_backpressure();
    int cyc, nre, aerr, bad;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(i + 5);
    end
    run_op(4, cyc, nre, aerr);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      start  = (k == 2);
      length = 5'd3;
      @(posedge clk); #1;
      if (result !== CW'(70) || result_valid !== 1'b1 || busy !== 1'b1 || read_en !== 1'b0)
        bad++;
    end
    start = 1'b0;
    tests++;
    if (bad != 0) begin
      $display("FAIL hold_result: got %0d bad cycles want 0 (res=%0d)", bad, result); fails++;
    end
    // start during the handshake cycle must be dropped too
    start = 1'b1;
    handshake();
    start = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || read_en !== 1'b0 || result !== CW'(70)) begin
      $display("FAIL hs_start_ignored: got busy=%b en=%b res=%0d want 0 0 70",
               busy, read_en, result);
      fails++;
    end
    run_op(3, cyc, nre, aerr);
    tests++;
    if (result !== CW'(38) || cyc != 5 || nre != 3) begin
      $display("FAIL after_hs_run: got res=%0d cyc=%0d reads=%0d want 38 5 3",
               result, cyc, nre);
      fails++;
    end
    handshake();
  endtask

  task automatic test_reset_abort();
    int cyc, nre, aerr;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = DW'(9);
      mem_b[i] = DW'(9);
    end
    @(posedge clk); #1;
    start  = 1'b1;
    length = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (read_en !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL abort_in_read: got en=%b busy=%b want 1 1", read_en, busy); fails++;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({read_en, read_address, busy, result, result_valid} !== '0) begin
      $display("FAIL abort_outputs: got en=%b addr=%0d busy=%b res=%0d v=%b want all 0",
               read_en, read_address, busy, result, result_valid);
      fails++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_a[0] = 8'd3; mem_a[1] = 8'd4;
    mem_b[0] = 8'd5; mem_b[1] = 8'd6;
    run_op(2, cyc, nre, aerr);
    tests++;
    if (result !== CW'(39) || cyc != 4) begin
      $display("FAIL abort_rerun: got res=%0d cyc=%0d want 39 4", result, cyc); fails++;
    end
    handshake();
  endtask

  task automatic test_signedness();
    int cyc, nre, aerr;
    logic [CW-1:0] exp;
`ifdef DOT_SIGNED_EN
    exp = CW'(20'hFFF7E);
`else
    exp = CW'(20'h0027E);
`endif
    mem_a[0] = 8'hFF; mem_a[1] = 8'h80;
    mem_b[0] = 8'h02; mem_b[1] = 8'h01;
    run_op(2, cyc, nre, aerr);
    tests++;
    if (result !== exp) begin
      $display("FAIL sign_result: got %0h want %0h", result, exp); fails++;
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_length();
    test_zero_length();
    test_backpressure();
    test_reset_abort();
    test_signedness();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
